cmem_stream: RTL and testbench

Parametrised coefficient memory for the FIR datapath. It generalises the fixed 64x16 coefficient store to configurable word width and depth. It keeps the same active-low host port (cen/wen/a/d/q) and adds a tap-streaming read port that plays coefficients 0..ntaps-1 out one per cycle to the MAC stage. With the optional written-bitmap, reads of never-written entries return zero and are flagged, instead of returning X.

---
 rtl/cmem_stream.sv | 181 ++++++++++++++++++
 tb/tb_cmem_stream.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cmem_stream.sv
// Parametrised FIR coefficient memory: active-low host port plus a tap-streaming read port.
// Define CMEM_ZERO_UNWR_EN to build the written-bitmap (unwritten reads return 0 and raise q_unwr).
module cmem_stream #(
    parameter int DW    = 16,
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cen,
    input  logic          wen,
    input  logic [AW-1:0] a,
    input  logic [DW-1:0] d,
    output logic [DW-1:0] q,
    output logic          q_unwr,
    output logic          hbusy,
    input  logic          start,
    input  logic [AW:0]   ntaps,
    output logic [DW-1:0] c,
    output logic          c_valid,
    output logic          c_last,
    output logic [AW-1:0] c_idx
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW-1:0] lastAddr_q, lastAddr_d;
    logic [DW-1:0] q_q, q_d;
    logic [DW-1:0] c_q, c_d;
    logic          cValid_q, cValid_d;
    logic          cLast_q, cLast_d;
    logic [AW-1:0] cIdx_q, cIdx_d;

    logic [DW-1:0] mem [DEPTH];

    logic          inRange;
    logic          hostRd;
    logic          hostWr;
    logic [DW-1:0] hostRdata;
    logic [DW-1:0] streamRdata;
    logic [AW:0]   load;

    // Power-of-two depths cannot be addressed out of range, so skip the compare there.
    if ((1 << AW) == DEPTH) begin : g_pow2
        assign inRange = 1'b1;
    end else begin : g_npow2
        assign inRange = ({1'b0, a} < DEPTH_W);
    end

    assign hbusy  = (state_q != IDLE);
    assign hostRd = !rst && !cen && !hbusy && wen;
    assign hostWr = !rst && !cen && !hbusy && !wen && inRange;
    assign load   = (ntaps > DEPTH_W) ? DEPTH_W : ntaps;

`ifdef CMEM_ZERO_UNWR_EN
    logic [DEPTH-1:0] written_q;
    logic             hostUnwr;
    logic             unwr_q;

    always_comb begin
        hostRdata   = mem[a];
        hostUnwr    = 1'b0;
        streamRdata = mem[addr_q];
        if (!inRange || !written_q[a]) begin
            hostRdata = '0;
            hostUnwr  = 1'b1;
        end
        if (!written_q[addr_q]) begin
            streamRdata = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            written_q <= '0;
            unwr_q    <= 1'b0;
        end else begin
            if (hostWr) begin
                written_q[a] <= 1'b1;
            end
            if (hostRd) begin
                unwr_q <= hostUnwr;
            end
        end
    end

    assign q_unwr = unwr_q;
`else
    always_comb begin
        hostRdata   = inRange ? mem[a] : '0;
        streamRdata = mem[addr_q];
    end

    assign q_unwr = 1'b0;
`endif

    // Array contents survive reset; only the control/output registers are cleared.
    always_ff @(posedge clk) begin
        if (hostWr) begin
            mem[a] <= d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        lastAddr_d = lastAddr_q;
        q_d        = q_q;
        c_d        = c_q;
        cValid_d   = 1'b0;
        cLast_d    = 1'b0;
        cIdx_d     = cIdx_q;

        if (hostRd) begin
            q_d = hostRdata;
        end

        case (state_q)
            IDLE: begin
                if (start && (ntaps != '0)) begin
                    state_d    = RUN;
                    addr_d     = '0;
                    lastAddr_d = AW'(load - (AW+1)'(1));
                end
            end
            RUN: begin
                c_d      = streamRdata;
                cValid_d = 1'b1;
                cIdx_d   = addr_q;
                addr_d   = addr_q + AW'(1);
                if (addr_q == lastAddr_q) begin
                    cLast_d = 1'b1;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            lastAddr_q <= '0;
            q_q        <= '0;
            c_q        <= '0;
            cValid_q   <= 1'b0;
            cLast_q    <= 1'b0;
            cIdx_q     <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            lastAddr_q <= lastAddr_d;
            q_q        <= q_d;
            c_q        <= c_d;
            cValid_q   <= cValid_d;
            cLast_q    <= cLast_d;
            cIdx_q     <= cIdx_d;
        end
    end

    assign q       = q_q;
    assign c       = c_q;
    assign c_valid = cValid_q;
    assign c_last  = cLast_q;
    assign c_idx   = cIdx_q;

endmodule

// File: tb/tb_cmem_stream.sv
// Scoreboard bench for cmem_stream: drivers queue expectations, a monitor compares as outputs appear.
// Expectations follow CMEM_ZERO_UNWR_EN when the bench is built with it.
module tb_cmem_stream;

    localparam int DW    = 16;
    localparam int DEPTH = 64;
    localparam int AW    = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cen = 1'b1;
    logic          wen = 1'b1;
    logic [AW-1:0] a = '0;
    logic [DW-1:0] d = '0;
    logic [DW-1:0] q;
    logic          q_unwr;
    logic          hbusy;
    logic          start = 1'b0;
    logic [AW:0]   ntaps = '0;
    logic [DW-1:0] c;
    logic          c_valid;
    logic          c_last;
    logic [AW-1:0] c_idx;

    cmem_stream #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst(rst), .cen(cen), .wen(wen), .a(a), .d(d),
        .q(q), .q_unwr(q_unwr), .hbusy(hbusy),
        .start(start), .ntaps(ntaps),
        .c(c), .c_valid(c_valid), .c_last(c_last), .c_idx(c_idx)
    );

    always #5 clk = ~clk;

    typedef enum {K_Q, K_QUNWR, K_HBUSY, K_CVALID, K_CLAST, K_C, K_CIDX} kind_e;
    typedef struct {
        int          due;
        kind_e       kind;
        logic [31:0] exp;
    } chk_t;
    typedef struct {
        int            due;
        logic [DW-1:0] c;
        logic [AW-1:0] idx;
        logic          last;
    } strm_t;

    chk_t  chkQ[$];
    strm_t strmQ[$];
    int    cyc = 0;
    int    compared = 0;
    int    mismatched = 0;

`ifdef CMEM_ZERO_UNWR_EN
    localparam bit ZERO_UNWR = 1'b1;
`else
    localparam bit ZERO_UNWR = 1'b0;
`endif

    function automatic string kindName(input kind_e k);
        case (k)
            K_Q:      return "q";
            K_QUNWR:  return "q_unwr";
            K_HBUSY:  return "hbusy";
            K_CVALID: return "c_valid";
            K_CLAST:  return "c_last";
            K_C:      return "c_hold";
            default:  return "c_idx";
        endcase
    endfunction

    function automatic logic [31:0] actualOf(input kind_e k);
        case (k)
            K_Q:      return 32'(q);
            K_QUNWR:  return 32'(q_unwr);
            K_HBUSY:  return 32'(hbusy);
            K_CVALID: return 32'(c_valid);
            K_CLAST:  return 32'(c_last);
            K_C:      return 32'(c);
            default:  return 32'(c_idx);
        endcase
    endfunction

    task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d expected %0d at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    task automatic expectAt(input kind_e k, input logic [31:0] v, input int due);
        chk_t e;
        e.due  = due;
        e.kind = k;
        e.exp  = v;
        chkQ.push_back(e);
    endtask

    task automatic expectStream(input int due, input logic [DW-1:0] cv, input logic [AW-1:0] idx, input logic last);
        strm_t s;
        s.due  = due;
        s.c    = cv;
        s.idx  = idx;
        s.last = last;
        strmQ.push_back(s);
    endtask

    // Monitor: compares every expectation due this cycle and every presented coefficient.
    always @(posedge clk) begin
        cyc++;
        #1;
        for (int i = chkQ.size() - 1; i >= 0; i--) begin
            if (chkQ[i].due == cyc) begin
                checkOutput(kindName(chkQ[i].kind), actualOf(chkQ[i].kind), chkQ[i].exp);
                chkQ.delete(i);
            end
        end
        if (c_valid) begin
            if (strmQ.size() == 0) begin
                checkOutput("stray_c_valid", 32'(c_valid), 32'd0);
            end else begin
                strm_t s;
                s = strmQ.pop_front();
                checkOutput("c_cycle", 32'(cyc), 32'(s.due));
                checkOutput("c", 32'(c), 32'(s.c));
                checkOutput("c_idx_stream", 32'(c_idx), 32'(s.idx));
                checkOutput("c_last_stream", 32'(c_last), 32'(s.last));
            end
        end else if (strmQ.size() > 0 && strmQ[0].due <= cyc) begin
            checkOutput("missing_c_valid", 32'(c_valid), 32'd1);
            void'(strmQ.pop_front());
        end
    end

    // Drives one cycle of inputs at the falling edge; due is the rising edge that samples them.
    task automatic applyStimulus(input logic cenV, input logic wenV, input logic [AW-1:0] aV,
                                 input logic [DW-1:0] dV, input logic startV, input logic [AW:0] nV,
                                 output int due);
        @(negedge clk);
        cen   = cenV;
        wen   = wenV;
        a     = aV;
        d     = dV;
        start = startV;
        ntaps = nV;
        due   = cyc + 1;
    endtask

    task automatic idle(input int n);
        int e;
        for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b1, '0, '0, 1'b0, '0, e);
    endtask

    task automatic hostWrite(input logic [AW-1:0] addr, input logic [DW-1:0] data);
        int e;
        applyStimulus(1'b0, 1'b0, addr, data, 1'b0, '0, e);
    endtask

    task automatic hostRead(input logic [AW-1:0] addr, input logic [DW-1:0] expQ,
                            input logic expUnwr, input bit checkQ);
        int e;
        applyStimulus(1'b0, 1'b1, addr, '0, 1'b0, '0, e);
        if (checkQ) expectAt(K_Q, 32'(expQ), e);
        expectAt(K_QUNWR, 32'(expUnwr), e);
    endtask

    task automatic pulseStart(input logic [AW:0] n, output int e0);
        applyStimulus(1'b1, 1'b1, '0, '0, 1'b1, n, e0);
    endtask

    task automatic doReset();
        int e;
        @(negedge clk);
        rst = 1'b1;
        e   = cyc + 1;
        expectAt(K_Q, 0, e);
        expectAt(K_QUNWR, 0, e);
        expectAt(K_HBUSY, 0, e);
        expectAt(K_C, 0, e);
        expectAt(K_CVALID, 0, e);
        expectAt(K_CLAST, 0, e);
        expectAt(K_CIDX, 0, e);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int e0;

        doReset();

        // Never-written entry after reset.
        hostRead(6'd12, 16'd0, ZERO_UNWR, ZERO_UNWR);
        idle(1);

        hostWrite(6'd4, 16'd4001);
        hostWrite(6'd32, 16'd62);
        hostRead(6'd4, 16'd4001, 1'b0, 1'b1);
        idle(1);

        for (int i = 0; i < 8; i++) hostWrite(AW'(i), DW'(i + 100));

        // Eight-tap stream with a dropped write and an ignored read while busy.
        pulseStart(7'd8, e0);
        for (int k = 0; k < 8; k++) expectStream(e0 + 1 + k, DW'(100 + k), AW'(k), k == 7);
        expectAt(K_HBUSY, 1, e0);
        expectAt(K_HBUSY, 1, e0 + 8);
        expectAt(K_HBUSY, 0, e0 + 9);
        expectAt(K_CVALID, 0, e0 + 9);
        expectAt(K_CLAST, 0, e0 + 9);
        expectAt(K_C, 107, e0 + 9);
        hostWrite(6'd3, 16'd999);
        hostRead(6'd5, 16'd4001, 1'b0, 1'b1);
        idle(10);
        hostRead(6'd3, 16'd103, 1'b0, 1'b1);
        idle(1);

        // Zero-length request is ignored.
        pulseStart(7'd0, e0);
        expectAt(K_HBUSY, 0, e0);
        expectAt(K_HBUSY, 0, e0 + 1);
        expectAt(K_CVALID, 0, e0 + 1);
        idle(3);

        // Oversized request clamps to DEPTH.
        for (int i = 8; i < DEPTH; i++) hostWrite(AW'(i), DW'(i + 100));
        pulseStart(7'(DEPTH + 1), e0);
        for (int k = 0; k < DEPTH; k++) expectStream(e0 + 1 + k, DW'(100 + k), AW'(k), k == DEPTH - 1);
        expectAt(K_HBUSY, 1, e0 + DEPTH);
        expectAt(K_HBUSY, 0, e0 + DEPTH + 1);
        expectAt(K_CVALID, 0, e0 + DEPTH + 1);
        idle(DEPTH + 4);

        // Reset on the third valid coefficient abandons the stream.
        pulseStart(7'd8, e0);
        for (int k = 0; k < 3; k++) expectStream(e0 + 1 + k, DW'(100 + k), AW'(k), 1'b0);
        idle(3);
        doReset();
        hostRead(6'd5, ZERO_UNWR ? 16'd0 : 16'd105, ZERO_UNWR, 1'b1);
        idle(5);

        foreach (chkQ[i]) checkOutput({"unchecked_", kindName(chkQ[i].kind)}, 32'(chkQ[i].due), 32'(cyc + 1));
        foreach (strmQ[i]) checkOutput("unseen_coefficient", 32'(strmQ[i].idx), 32'hFFFF_FFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
